// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the encrypt (and decrypt) datapaths: FSM state
// encoding, round count, byte/word/block/matrix typedefs, the forward S-box
// and the GF(2^8) xtime helper (reduction polynomial x^8+x^4+x^3+x+1).
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int DATA_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0] byte_t;
    typedef logic [31:0]           word_t;
    typedef logic [127:0]          block_t;

    // State matrix indexed [column][row]. Because index 0 is the leftmost
    // packed element, m[c][r] lands on bits [127-32c-8r -: 8], which is the
    // column-major, byte-0-is-MSB mapping used on the block ports.
    typedef byte_t [0:3][0:3] matrix_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } enc_state_t;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic byte_t sbox(input byte_t b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8): shift, then fold the overflow bit back in.
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// -----------------------------------------------------------------------------
// aes_key_step
// Combinational AES-128 key-schedule step: derives the next round key from
// the current one and the round constant.
//   rk      in  128  current round key (w0 in bits [127:96])
//   rcon    in  8    round constant for this step
//   rk_next out 128  next round key
// -----------------------------------------------------------------------------
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk,
    input  byte_t        rcon,
    output logic [127:0] rk_next
);

    word_t w0, w1, w2, w3;
    word_t rot_w3, sub_w3;
    word_t n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk;

    assign rot_w3 = {w3[23:0], w3[31:24]};
    assign sub_w3 = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                     sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};

    // Each word chains on the freshly computed previous word.
    assign n0 = w0 ^ sub_w3 ^ {rcon, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_enc_iter.sv
// -----------------------------------------------------------------------------
// aes128_enc_iter
// Iterative AES-128 encryption core: one round per clock, round keys
// expanded on the fly, ciphertext returned over a valid/ready handshake.
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    plaintext/key present
//   in_ready   out  1    core idle, can accept a block
//   in_data    in   128  plaintext
//   in_key     in   128  cipher key
//   out_valid  out  1    ciphertext present
//   out_ready  in   1    consumer accepts ciphertext
//   out_data   out  128  ciphertext (held until the handshake)
//   busy       out  1    rounds in progress
// -----------------------------------------------------------------------------
module aes128_enc_iter
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
    parameter int DATA_WIDTH = aes_pkg::DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [16*DATA_WIDTH-1:0]  in_data,
    input  logic [16*DATA_WIDTH-1:0]  in_key,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [16*DATA_WIDTH-1:0]  out_data,
    output logic                      busy
);

    // ---------------------------------------------------------------- round ops
    function automatic matrix_t sub_bytes(input matrix_t m);
        matrix_t r;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
                r[c][k] = sbox(m[c][k]);
        return r;
    endfunction

    // Row k rotates left by k columns.
    function automatic matrix_t shift_rows(input matrix_t m);
        matrix_t r;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
                r[c][k] = m[(c + k) % 4][k];
        return r;
    endfunction

    // Column times {02 03 01 01} circulant; 3*a is xtime(a)^a.
    function automatic matrix_t mix_columns(input matrix_t m);
        matrix_t r;
        for (int c = 0; c < 4; c++) begin
            r[c][0] = xtime(m[c][0]) ^ xtime(m[c][1]) ^ m[c][1] ^ m[c][2] ^ m[c][3];
            r[c][1] = m[c][0] ^ xtime(m[c][1]) ^ xtime(m[c][2]) ^ m[c][2] ^ m[c][3];
            r[c][2] = m[c][0] ^ m[c][1] ^ xtime(m[c][2]) ^ xtime(m[c][3]) ^ m[c][3];
            r[c][3] = xtime(m[c][0]) ^ m[c][0] ^ m[c][1] ^ m[c][2] ^ xtime(m[c][3]);
        end
        return r;
    endfunction

    // ---------------------------------------------------------------- registers
    enc_state_t  fsm_q, fsm_d;
    block_t      blk_q;
    block_t      rk_q;
    byte_t       rcon_q;
    logic [3:0]  round_q;
    block_t      out_data_q;
    logic        out_valid_q;

    // ---------------------------------------------------------------- datapath
    block_t  rk_next;
    matrix_t sr_m;
    matrix_t mc_m;
    block_t  round_out;

    logic    accept;
    logic    step;
    logic    last;

    aes_key_step u_key_step (
        .rk      (rk_q),
        .rcon    (rcon_q),
        .rk_next (rk_next)
    );

    assign sr_m      = shift_rows(sub_bytes(blk_q));
    assign mc_m      = mix_columns(sr_m);
    // The final round skips MixColumns.
    assign round_out = (last ? block_t'(sr_m) : block_t'(mc_m)) ^ rk_next;

    // ---------------------------------------------------------------- FSM
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        fsm_d  = fsm_q;
        accept = 1'b0;
        step   = 1'b0;
        last   = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    fsm_d  = ROUND;
                end
            end
            ROUND: begin
                step = 1'b1;
                if (round_q == NUM_ROUNDS[3:0]) begin
                    last  = 1'b1;
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the wide datapath registers are reset too, so an aborted
            // block leaves nothing behind and out_data reads zero after reset.
            fsm_q       <= IDLE;
            blk_q       <= '0;
            rk_q        <= '0;
            rcon_q      <= 8'h01;
            round_q     <= 4'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            out_valid_q <= (fsm_d == DONE);
            if (accept) begin
                blk_q   <= in_data ^ in_key;
                rk_q    <= in_key;
                rcon_q  <= 8'h01;
                round_q <= 4'd1;
            end else if (step) begin
                blk_q  <= round_out;
                rk_q   <= rk_next;
                rcon_q <= xtime(rcon_q);
                // Counter stops at the last round rather than wrapping.
                if (!last) round_q <= round_q + 4'd1;
            end
            if (step && last) out_data_q <= round_out;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q == ROUND);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes128_enc_iter.sv
// -----------------------------------------------------------------------------
// tb_aes128_enc_iter
// Self-checking bench for aes128_enc_iter: known-answer vectors go into a
// scoreboard queue at issue time; a negedge monitor pops and compares on
// every output handshake. Handshake timing, backpressure, input isolation
// and mid-round reset are checked inline.
// -----------------------------------------------------------------------------
module tb_aes128_enc_iter;

    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    aes128_enc_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] sb [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares whenever a handshake is about to occur.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %h required no output", out_data);
            end else begin
                check("ciphertext", out_data, sb.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one block: wait for in_ready, queue the expected result, and
    // return the cycle count of the accept edge. Ends at posedge+1.
    task automatic send(input logic [127:0] pt, input logic [127:0] key,
                        input logic [127:0] exp, output int acc_cyc);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = pt;
        in_key   = key;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        acc_cyc = -1;
        if (!ok) begin
            check("accept_timeout", 128'd0, 128'd1);
            in_valid = 1'b0;
        end else begin
            sb.push_back(exp);
            @(posedge clk);
            #1;
            acc_cyc  = cyc;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        int  lat, a1, a2, a3, dummy;
        bit  seen, reaccept, stable, ir_low;
        logic [127:0] held;

        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready",  128'(in_ready),  128'd1);
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_busy",      128'(busy),      128'd0);
        check("reset_out_data",  out_data,        128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // App. B with latency measurement and input corruption after accept.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = B_PT;
        in_key   = B_KEY;
        sb.push_back(B_CT);
        @(posedge clk);
        #1;
        lat = 0;
        seen = 0;
        reaccept = 0;
        for (int i = 0; i < 30; i++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_key  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            lat++;
            if (out_valid) begin
                seen = 1;
                break;
            end
            if (in_ready) reaccept = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("out_valid_seen", 128'(seen), 128'd1);
        check("latency_cycles", 128'(lat), 128'd11);
        check("no_reaccept", 128'(reaccept), 128'd0);
        @(posedge clk);
        @(negedge clk);
        check("post_hs_in_ready",  128'(in_ready),  128'd1);
        check("post_hs_out_valid", 128'(out_valid), 128'd0);

        // Back-to-back: App. B, App. C.1, all-zero.
        @(posedge clk);
        #1;
        send(B_PT,  B_KEY,  B_CT,  a1);
        send(C1_PT, C1_KEY, C1_CT, a2);
        send('0,    '0,     Z_CT,  a3);
        check("throughput_1", 128'(a2 - a1), 128'd12);
        check("throughput_2", 128'(a3 - a2), 128'd12);
        wait_drain();

        // Backpressure: hold out_ready low for 20 cycles after out_valid.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(C1_PT, C1_KEY, C1_CT, dummy);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        check("bp_out_valid_seen", 128'(seen), 128'd1);
        held   = out_data;
        stable = 1;
        ir_low = 1;
        repeat (20) begin
            @(negedge clk);
            if (out_data !== held || !out_valid) stable = 0;
            if (in_ready) ir_low = 0;
        end
        check("bp_data_held", held, C1_CT);
        check("bp_stable", 128'(stable), 128'd1);
        check("bp_in_ready_low", 128'(ir_low), 128'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_post_in_ready",  128'(in_ready),  128'd1);
        check("bp_post_out_valid", 128'(out_valid), 128'd0);
        check("bp_single_hs", 128'(sb.size()), 128'd0);

        // Reset during round 5, then a fresh App. B block.
        @(posedge clk);
        #1;
        send(B_PT, B_KEY, B_CT, dummy);
        repeat (5) @(posedge clk);
        #1;
        check("busy_mid_round", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy",      128'(busy),      128'd0);
        check("abort_in_ready",  128'(in_ready),  128'd1);
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_out_data",  out_data,        128'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(B_PT, B_KEY, B_CT, dummy);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes128_enc_iter.md
# aes128_enc_iter

Iterative AES-128 encryption core, the forward counterpart of the decryption round datapath. It accepts one 128-bit plaintext and key per transaction and computes one round per clock. Round keys are expanded on the fly. It returns the ciphertext through a valid/ready handshake and sits beside the decrypt path in the AES engine.

## Interface
- `NUM_ROUNDS`, default 10: AES-128 round count. Fixed; any other value is unsupported.
- `DATA_WIDTH`, default 8: byte width of state matrix cells.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  plaintext/key present.
- `in_ready`  out  1  core can accept a block.
- `in_data`  in  128  plaintext.
- `in_key`  in  128  cipher key.
- `out_valid`  out  1  ciphertext present.
- `out_ready`  in  1  consumer accepts ciphertext.
- `out_data`  out  128  ciphertext.
- `busy`  out  1  high in ROUND state.

## Operation
- Byte mapping for `in_data`, `in_key` and `out_data`: state[r][c] = bits [127-32c-8r -: 8], i.e. column-major, byte 0 is the MSB. This matches the decrypt path.
- FSM states are IDLE, ROUND and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, register state = `in_data` ^ `in_key`, rk = `in_key`, rcon = 8'h01, round = 1. Go to ROUND.
- ROUND: each cycle performs the following.
  - rk_next = key_step(rk, rcon).
  - state = AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk_next) for rounds 1-9.
  - MixColumns is omitted in round 10.
  - rcon advances by xtime: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - round increments.
  - After round 10, register `out_data` and go to DONE.
- DONE:
  - `out_valid`=1 and `out_data` held stable until `out_valid && out_ready`; then go to IDLE.
  - `out_ready` low stalls indefinitely with no data change.
- Inputs are sampled only on the accept edge. `in_data` and `in_key` may change afterwards without effect.
- `in_valid` during ROUND or DONE is ignored (`in_ready`=0). No pipelining or overlap of blocks.
- `round` counter is 4 bits, range 1..10, never wraps. Any unreachable FSM encoding returns to IDLE.
- All GF(2^8) arithmetic is mod x^8+x^4+x^3+x+1. XOR only; no carries.

## Timing
- Reset values: FSM=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0, internal state/rk=0, rcon=8'h01, round=0.
- Reset assertion mid-ROUND or in DONE aborts immediately and asynchronously. The partial result is discarded and never presented.
- `in_ready` and `busy` decode from the FSM register; `out_valid` is registered.
- Latency: accept at edge E0 (initial AddRoundKey). Rounds occur at edges E1..E10. `out_valid`=1 in the cycle following E10, so accept to `out_valid` is 11 cycles.
- Output handshake at edge Eh makes `in_ready`=1 in the following cycle. The earliest next accept is at Eh+1.
- Throughput without stall: one block per 12 cycles.

## Structure
- Package `aes_pkg` holds:
  - FSM enum `enc_state_t` (IDLE, ROUND, DONE).
  - `NUM_ROUNDS`.
  - SBOX constant array and `sbox()` function.
  - `xtime()` function.
  - Byte/matrix typedefs shared with the decrypt path.
- Sub-module `aes_key_step` is combinational. Input: rk[127:0], rcon[7:0]. Output: the next round key.
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w1' = w1 ^ w0'.
  - w2' = w2 ^ w1'.
  - w3' = w3 ^ w2'.
- Forward SubBytes/ShiftRows/MixColumns are inline functions in the round logic. They must not use clocked sub-instances.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> `out_data` 3925841d02dc09fbdc118597196a0b32, `out_valid` exactly 11 cycles after accept.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Backpressure: `out_ready`=0 for 20 cycles after `out_valid` -> `out_data` constant, `in_ready`=0 throughout. On `out_ready`=1, a single handshake occurs, then `in_ready`=1 the next cycle.
- Input corruption: change `in_data`/`in_key` and hold `in_valid`=1 every cycle after accept -> first ciphertext unaffected, no second accept before the output handshake. Back-to-back vectors B then C.1 both correct.
- Reset at round 5: `rst_n` low mid-ROUND -> outputs return immediately to reset values (`busy`=0, `in_ready`=1, `out_valid`=0, `out_data`=0). A new App. B transaction after release yields the correct ciphertext.
